// File: rtl/gate_settle_sequencer.sv
// Drives one stimulus vector onto the OR/AND gate cell, waits for the gates to
// settle, then samples the cell outputs and checks them against {c|d, b&c}.
`timescale 1ns/1ps
module gate_settle_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [2:0]       vec_data,
  input  logic             abort,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  input  logic             dut_a,
  input  logic             dut_e,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_data,
  output logic             res_mismatch,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             clr_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, REPORT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [1:0] exp_val;
  logic [1:0] sampled;
  logic       accept;
  logic       capture;
  logic       handshake;
  logic       mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    if (val == {ERR_W{1'b1}}) return val;
    return val + 1'b1;
  endfunction

  assign vec_ready = (state == IDLE);
  assign sampled   = {dut_a, dut_e};
  assign mismatch  = (sampled != exp_val);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (vec_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) state_nxt = IDLE;
        else if (cnt == 4'd0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // An abort landing on the capture edge wins: nothing is reported.
        if (abort) state_nxt = IDLE;
        else begin
          capture   = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      exp_val <= 2'b00;
      dut_b   <= 1'b0;
      dut_c   <= 1'b0;
      dut_d   <= 1'b0;
    end else if (accept) begin
      {dut_b, dut_c, dut_d} <= vec_data;
      exp_val               <= {vec_data[1] | vec_data[0], vec_data[2] & vec_data[1]};
      cnt                   <= CNT_LOAD;
    end else if (state == SETTLE && !abort && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_data     <= 2'b00;
      res_mismatch <= 1'b0;
    end else if (capture) begin
      res_valid    <= 1'b1;
      res_data     <= sampled;
      res_mismatch <= mismatch;
    end else if (handshake) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (capture && mismatch) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_gate_settle_sequencer.sv
// Bench for gate_settle_sequencer with a behavioural OR/AND gate cell and an
// optional stuck-at-1 fault on the AND output.
`timescale 1ns/1ps
module tb_gate_settle_sequencer;

  localparam int SETTLE = 4;
  localparam int EW     = 8;

  logic          clk;
  logic          rst_n;
  logic          vec_valid;
  logic          vec_ready;
  logic [2:0]    vec_data;
  logic          abort;
  logic          dut_b, dut_c, dut_d;
  logic          dut_a, dut_e;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_data;
  logic          res_mismatch;
  logic [EW-1:0] err_cnt;
  logic          clr_err;
  logic          stuck_e;

  wire cell_a;
  wire cell_e;
  assign #3 cell_a = dut_c | dut_d;
  assign #2 cell_e = dut_b & dut_c;
  assign dut_a = cell_a;
  assign dut_e = stuck_e ? 1'b1 : cell_e;

  gate_settle_sequencer #(.SETTLE_CYCLES(SETTLE), .ERR_W(EW)) u_dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .abort(abort), .dut_b(dut_b), .dut_c(dut_c),
    .dut_d(dut_d), .dut_a(dut_a), .dut_e(dut_e), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_mismatch(res_mismatch),
    .err_cnt(err_cnt), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] vec;
    logic [1:0] res;
  } vec_t;

  vec_t tbl [8];
  int   n_cmp = 0;
  int   n_err = 0;
  time  acc_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Presents v at the current negedge, then checks accept, latency and result.
  task automatic send(input logic [2:0] v, input logic [1:0] exp_d, input logic exp_mm,
                      input logic [EW-1:0] exp_err, input string nm);
    int   lat;
    logic ready_seen;
    chk({nm, " vec_ready before accept"}, 32'(vec_ready), 32'd1);
    vec_valid = 1'b1;
    vec_data  = v;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    vec_valid = 1'b0;
    chk({nm, " dut bcd"}, 32'({dut_b, dut_c, dut_d}), 32'(v));
    lat        = 0;
    ready_seen = 1'b0;
    while (!res_valid && lat < 20) begin
      if (vec_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(SETTLE + 1));
    chk({nm, " vec_ready low while busy"}, 32'(ready_seen | vec_ready), 32'd0);
    chk({nm, " res_data"}, 32'(res_data), 32'(exp_d));
    chk({nm, " res_mismatch"}, 32'(res_mismatch), 32'(exp_mm));
    chk({nm, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  // With res_ready high, the next edge completes the handshake.
  task automatic handshake(input string nm);
    @(negedge clk);
    chk({nm, " res_valid cleared"}, 32'(res_valid), 32'd0);
    chk({nm, " vec_ready back"}, 32'(vec_ready), 32'd1);
  endtask

  task automatic quick_send(input logic [2:0] v);
    int lat;
    vec_valid = 1'b1;
    vec_data  = v;
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    time  prev_t;
    logic bad;
    logic [EW-1:0] err_before;

    tbl[0] = '{3'b000, 2'b00};
    tbl[1] = '{3'b001, 2'b10};
    tbl[2] = '{3'b010, 2'b10};
    tbl[3] = '{3'b011, 2'b10};
    tbl[4] = '{3'b100, 2'b00};
    tbl[5] = '{3'b101, 2'b10};
    tbl[6] = '{3'b110, 2'b11};
    tbl[7] = '{3'b111, 2'b11};

    rst_n = 1'b0; vec_valid = 1'b0; vec_data = 3'b000; abort = 1'b0;
    res_ready = 1'b1; clr_err = 1'b0; stuck_e = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset vec_ready", 32'(vec_ready), 32'd1);
    chk("reset dut bcd", 32'({dut_b, dut_c, dut_d}), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset res_data", 32'(res_data), 32'd0);
    chk("reset res_mismatch", 32'(res_mismatch), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(3'b011, 2'b10, 1'b0, 8'd0, "first");
    handshake("first");

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].vec, tbl[i].res, 1'b0, 8'd0, $sformatf("sweep%0d", i));
      if (i > 0) chk($sformatf("sweep%0d spacing", i), 32'((acc_t - prev_t) / 10), 32'd7);
      prev_t = acc_t;
      handshake($sformatf("sweep%0d", i));
    end

    stuck_e = 1'b1;
    send(3'b000, 2'b01, 1'b1, 8'd1, "stuck");
    handshake("stuck");
    for (int i = 0; i < 300; i++) quick_send(3'b000);
    chk("saturate err_cnt", 32'(err_cnt), 32'd255);

    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err pulse", 32'(err_cnt), 32'd0);

    send(3'b000, 2'b01, 1'b1, 8'd1, "pre-clr");
    handshake("pre-clr");
    vec_valid = 1'b1;
    vec_data  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (SETTLE) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr vs inc res_valid", 32'(res_valid), 32'd1);
    chk("clr vs inc mismatch", 32'(res_mismatch), 32'd1);
    chk("clr vs inc err_cnt", 32'(err_cnt), 32'd0);
    handshake("clr vs inc");
    stuck_e = 1'b0;

    res_ready = 1'b0;
    send(3'b101, 2'b10, 1'b0, 8'd0, "hold");
    vec_valid = 1'b1;
    vec_data  = 3'b010;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_data != 2'b10 || vec_ready || {dut_b, dut_c, dut_d} != 3'b101)
        bad = 1'b1;
    end
    chk("hold stable", 32'(bad), 32'd0);
    vec_valid = 1'b0;
    res_ready = 1'b1;
    handshake("hold release");

    err_before = err_cnt;
    vec_valid = 1'b1;
    vec_data  = 3'b110;
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort idle", 32'(vec_ready), 32'd1);
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) bad = 1'b1;
    end
    chk("abort no result", 32'(bad), 32'd0);
    chk("abort err_cnt", 32'(err_cnt), 32'(err_before));
    chk("abort dut bcd", 32'({dut_b, dut_c, dut_d}), 32'b110);

    stuck_e = 1'b1;
    send(3'b000, 2'b01, 1'b1, 8'd1, "pre-reset");
    handshake("pre-reset");
    stuck_e = 1'b0;
    vec_valid = 1'b1;
    vec_data  = 3'b111;
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dut bcd", 32'({dut_b, dut_c, dut_d}), 32'd0);
    chk("async reset vec_ready", 32'(vec_ready), 32'd1);
    chk("async reset res_valid", 32'(res_valid), 32'd0);
    chk("async reset err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || !vec_ready) bad = 1'b1;
    end
    chk("after reset idle", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_settle_sequencer.md
# gate_settle_sequencer

Synchronous test sequencer for the primitive-gate cell (OR, inertial delay 3, output a = c | d; AND, rise 2 / fall 1, output e = b & c). It accepts input vectors over a valid/ready handshake and drives them onto the cell inputs b, c and d. It then waits a programmable number of clock cycles for the gate delays to settle, samples a and e, and compares them against the golden Boolean result. It sits between the bench or BIST stimulus source and the gate cell, and keeps a saturating mismatch count.

## Interface
- SETTLE_CYCLES, default 4: cycles held in SETTLE before capture. Legal range 1..15. Clock period × SETTLE_CYCLES must exceed the worst cell delay of 3 time units.
- ERR_W, default 8: width of the mismatch counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- vec_valid  input  1  stimulus vector present.
- vec_ready  output  1  sequencer can accept a vector.
- vec_data  input  3  {b, c, d}; bit 2 = b, bit 1 = c, bit 0 = d.
- abort  input  1  drop the in-flight vector and return to IDLE.
- dut_b, dut_c, dut_d  output  1 each  registered drives to the cell inputs.
- dut_a, dut_e  input  1 each  cell outputs.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_data  output  2  captured {a, e}.
- res_mismatch  output  1  captured value differs from expected.
- err_cnt  output  ERR_W  saturating count of mismatches.
- clr_err  input  1  synchronous clear of err_cnt.

## Operation
- Reset values:
  - state = IDLE.
  - vec_ready = 1.
  - dut_b, dut_c, dut_d = 0.
  - res_valid = 0, res_data = 2'b00, res_mismatch = 0.
  - err_cnt = 0.
  - Settle counter = 0.
- FSM states: IDLE, SETTLE, CAPTURE, REPORT. vec_ready is high only in IDLE.
- IDLE: when vec_valid is high, the vector is accepted on that edge.
  - dut_{b,c,d} are loaded from vec_data.
  - The expected value {c|d, b&c} is registered.
  - The counter is loaded with SETTLE_CYCLES-1.
  - The FSM moves to SETTLE.
- SETTLE: the counter decrements each cycle. When it reaches 0, the FSM moves to CAPTURE.
- CAPTURE: lasts one cycle. At its closing edge:
  - res_data is loaded with {dut_a, dut_e}.
  - res_mismatch is set to (res_data != expected).
  - res_valid is set to 1.
  - The FSM moves to REPORT.
  - If the result mismatches, err_cnt increments, saturating at 2^ERR_W-1.
- REPORT: res_valid, res_data and res_mismatch are held stable until res_valid and res_ready are both high on an edge. That edge clears res_valid and moves the FSM to IDLE.
- dut_{b,c,d} keep the last applied vector until the next accept. They are never returned to 0 except by reset.
- abort in SETTLE or CAPTURE: the FSM returns to IDLE next edge. No result is produced, err_cnt is unchanged, and dut_* are unchanged. abort is ignored in IDLE and REPORT.
- clr_err and an increment on the same edge: clr_err wins, and err_cnt becomes 0.
- Reset asserted mid-operation: all state and outputs return to their reset values immediately, including dut_* going to 0. No partial result is retained.

## Timing
- The accept edge is edge k. dut_* change at k.
- The FSM is in SETTLE for edges k+1 … k+SETTLE_CYCLES.
- CAPTURE is closed by edge k+SETTLE_CYCLES+1, where res_valid rises. Latency from accept to result is SETTLE_CYCLES+1 cycles.
- dut_a and dut_e are sampled exactly at edge k+SETTLE_CYCLES+1. No earlier sample may affect res_data.
- The earliest next accept is the edge after the handshake edge, because vec_ready rises in IDLE. Minimum vector spacing is SETTLE_CYCLES+3 cycles with res_ready held high.
- err_cnt updates on the same edge as res_valid rises.

## Test plan
- Reset, then vec_data=3'b011 (b=0, c=1, d=1) with the real cell and a 10-unit clock period:
  - dut_{b,c,d} = 0,1,1 at edge k.
  - res_valid at k+5.
  - res_data = 2'b10, res_mismatch = 0, err_cnt = 0.
- Sweep all 8 vectors with res_ready held high:
  - Each result equals {c|d, b&c}.
  - vec_ready is low from the accept edge until the FSM returns to IDLE.
  - Vectors are spaced 7 cycles apart.
- Force dut_e stuck-at-1 and apply 3'b000:
  - res_data = 2'b01, res_mismatch = 1, err_cnt = 1.
  - Repeat 300 times with ERR_W=8: err_cnt saturates at 255.
- Hold res_ready low for 10 cycles in REPORT:
  - res_valid and res_data stay stable.
  - vec_valid is ignored.
  - Release res_ready: res_valid clears next edge.
- Apply 3'b110, then pulse abort at SETTLE cycle 2:
  - The FSM returns to IDLE with no res_valid and err_cnt unchanged.
  - dut_{b,c,d} stay at 1,1,0.
- Drive rst_n low mid-SETTLE, and separately drive clr_err together with a mismatching capture:
  - Reset: all outputs go to reset values asynchronously.
  - clr_err case: err_cnt = 0.
